// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares a single-ported synchronous memory between an instruction-fetch
// requester and a data (load/store) requester. One transaction is in flight
// at a time; it walks IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE. Data requests
// win ties, but once data has been granted STARVE_MAX times in a row while
// fetch was waiting, the next tie goes to fetch.
//
// Parameters
//   ADDR_W      word-address width
//   LAT         memory read latency in cycles (1..7)
//   STARVE_MAX  consecutive data grants tolerated while fetch waits (1..15)
//
// Ports
//   clk, reset            clock and synchronous active-high reset
//   if_req/if_addr        fetch request and address (held until if_ack)
//   if_ack/if_rdata       fetch completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata  data request, direction, address, store data
//   d_ack/d_rdata         data completion pulse and load data
//   mem_en/mem_we/mem_addr/mem_wdata  memory command (one cycle in ISSUE)
//   mem_rdata             memory read data, valid LAT cycles after mem_en
//   busy                  high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [2:0] WAIT_LOAD  = 3'(LAT - 1);

    state_t            state;
    state_t            state_next;
    logic              grant_data;
    logic              win_data;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [3:0]        streak;
    logic [2:0]        wait_cnt;

    // Arbitration: data wins unless fetch has been starved long enough.
    always_comb begin
        grant_data = d_req && !(if_req && (streak == STARVE_LIM));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Stores skip WAIT because nothing comes back.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (if_req || d_req) state_next = ISSUE;
            ISSUE:   state_next = (win_data && lat_we) ? DONE : WAIT;
            WAIT:    if (wait_cnt == 3'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latching, starvation tracking, latency counting and read-data
    // capture. A reset mid-transaction simply drops everything, so the
    // returning memory word is never captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_data  <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            streak    <= 4'd0;
            wait_cnt  <= 3'd0;
            if_rdata  <= 32'd0;
            d_rdata   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        win_data <= grant_data;
                        if (grant_data) begin
                            lat_we    <= d_we;
                            lat_addr  <= d_addr;
                            lat_wdata <= d_wdata;
                            if (if_req && (streak < STARVE_LIM)) begin
                                streak <= streak + 4'd1;
                            end
                        end else begin
                            lat_we    <= 1'b0;
                            lat_addr  <= if_addr;
                            lat_wdata <= 32'd0;
                            streak    <= 4'd0;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= WAIT_LOAD;
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        if (win_data) begin
                            d_rdata <= mem_rdata;
                        end else begin
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from registered state and latched request fields.
    assign mem_en    = (state == ISSUE);
    assign mem_we    = (state == ISSUE) && lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign if_ack    = (state == DONE) && !win_data;
    assign d_ack     = (state == DONE) && win_data;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter (LAT=2, STARVE_MAX=4) with a small
// behavioural memory that returns read data exactly two cycles after mem_en
// and drives a poison value otherwise.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [4:0]  if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [4:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int compared;
    int mismatched;

    mem_arbiter #(
        .ADDR_W    (5),
        .LAT       (2),
        .STARVE_MAX(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: preloaded on reset, two-stage read pipeline.
    logic [31:0] mem [32];
    logic [31:0] p1, p2;
    logic        v1, v2;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            mem[5] <= 32'hDEAD_BEEF;
            v1 <= 1'b0;
            v2 <= 1'b0;
            p1 <= 32'd0;
            p2 <= 32'd0;
        end else begin
            v1 <= mem_en && !mem_we;
            p1 <= mem[mem_addr];
            v2 <= v1;
            p2 <= p1;
            if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = v2 ? p2 : 32'h0BAD_0BAD;

    // Event monitor: memory grants (1 = fetch address 20), ack counts and
    // simultaneous-ack detection.
    int en_count;
    int if_ack_count;
    bit both_ack;
    bit grants[$];

    initial begin
        en_count     = 0;
        if_ack_count = 0;
        both_ack     = 1'b0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            en_count++;
            grants.push_back(mem_addr == 5'd20);
        end
        if (if_ack) if_ack_count++;
        if (if_ack && d_ack) both_ack = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        int en0;
        int ifack0;
        bit exp_grants[10];
        logic [31:0] g;

        compared   = 0;
        mismatched = 0;
        reset   = 1'b1;
        if_req  = 1'b0;
        if_addr = 5'd0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 5'd0;
        d_wdata = 32'd0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_if_ack", if_ack, 0);
        check("rst_d_ack", d_ack, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        tick();

        // Load from address 5
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'd5;
        tick();
        check("ld_mem_en_c1", mem_en, 1);
        check("ld_mem_addr_c1", mem_addr, 5);
        check("ld_mem_we_c1", mem_we, 0);
        check("ld_busy_c1", busy, 1);
        tick();
        check("ld_mem_en_c2", mem_en, 0);
        check("ld_d_ack_c2", d_ack, 0);
        tick();
        check("ld_d_ack_c3", d_ack, 0);
        tick();
        check("ld_d_ack_c4", d_ack, 1);
        check("ld_d_rdata_c4", d_rdata, 32'hDEAD_BEEF);
        check("ld_if_ack_c4", if_ack, 0);
        d_req = 1'b0;
        tick();
        check("ld_d_ack_c5", d_ack, 0);
        check("ld_busy_c5", busy, 0);
        check("ld_d_rdata_hold", d_rdata, 32'hDEAD_BEEF);

        // Store 0x12 to address 3
        d_req = 1'b1; d_we = 1'b1; d_addr = 5'd3; d_wdata = 32'h12;
        tick();
        check("st_mem_en_c1", mem_en, 1);
        check("st_mem_we_c1", mem_we, 1);
        check("st_mem_wdata_c1", mem_wdata, 32'h12);
        check("st_mem_addr_c1", mem_addr, 3);
        tick();
        check("st_d_ack_c2", d_ack, 1);
        check("st_d_rdata_keep", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        check("st_busy_c3", busy, 0);
        check("st_d_ack_c3", d_ack, 0);

        // Simultaneous fetch and data load: data first, fetch next
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'd3;
        if_req = 1'b1; if_addr = 5'd10;
        tick();
        check("tie_mem_addr_c1", mem_addr, 3);
        check("tie_mem_we_c1", mem_we, 0);
        tick();
        tick();
        tick();
        check("tie_d_ack_c4", d_ack, 1);
        check("tie_d_rdata_c4", d_rdata, 32'h12);
        check("tie_if_ack_c4", if_ack, 0);
        d_req = 1'b0;
        tick();
        check("tie_busy_c5", busy, 0);
        tick();
        check("tie_mem_en_c6", mem_en, 1);
        check("tie_mem_addr_c6", mem_addr, 10);
        check("tie_mem_we_c6", mem_we, 0);
        check("tie_mem_wdata_c6", mem_wdata, 0);
        tick();
        tick();
        tick();
        check("tie_if_ack_c9", if_ack, 1);
        check("tie_if_rdata_c9", if_rdata, 32'h1000_000A);
        check("tie_d_ack_c9", d_ack, 0);
        if_req = 1'b0;
        tick();
        check("tie_if_ack_c10", if_ack, 0);
        check("tie_busy_c10", busy, 0);

        // Reset during WAIT of a fetch abandons it
        if_req = 1'b1; if_addr = 5'd9;
        tick();
        check("rw_mem_en_c1", mem_en, 1);
        tick();
        reset = 1'b1;
        ifack0 = if_ack_count;
        tick();
        reset = 1'b0;
        if_req = 1'b0;
        check("rw_busy", busy, 0);
        check("rw_mem_en", mem_en, 0);
        check("rw_if_ack", if_ack, 0);
        check("rw_if_rdata", if_rdata, 0);
        for (int i = 0; i < 5; i++) tick();
        check("rw_no_if_ack", if_ack_count, ifack0);
        check("rw_if_rdata_after", if_rdata, 0);

        // Fresh fetch after reset completes normally
        if_req = 1'b1; if_addr = 5'd9;
        tick();
        check("rf_mem_en_c1", mem_en, 1);
        check("rf_mem_addr_c1", mem_addr, 9);
        tick();
        tick();
        tick();
        check("rf_if_ack_c4", if_ack, 1);
        check("rf_if_rdata_c4", if_rdata, 32'h1000_0009);
        if_req = 1'b0;
        tick();

        // Fetch request withdrawn during a data transaction is never served
        en0 = en_count;
        ifack0 = if_ack_count;
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'd5;
        tick();
        if_req = 1'b1; if_addr = 5'd17;
        tick();
        tick();
        if_req = 1'b0;
        tick();
        check("wd_d_ack_c4", d_ack, 1);
        check("wd_d_rdata_c4", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("wd_en_count", en_count, en0 + 1);
        check("wd_no_if_ack", if_ack_count, ifack0);
        check("wd_busy", busy, 0);

        // Starvation limit: 4 data grants, 1 fetch grant, data resumes
        reset = 1'b1;
        tick();
        reset = 1'b0;
        grants.delete();
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'd7;
        if_req = 1'b1; if_addr = 5'd20;
        for (int i = 0; i < 150; i++) begin
            if (grants.size() >= 10) break;
            tick();
        end
        d_req = 1'b0;
        if_req = 1'b0;
        check("sv_grant_count_ok", grants.size() >= 10, 1);
        exp_grants = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int i = 0; i < 10; i++) begin
            g = (i < grants.size()) ? 32'(grants[i]) : 32'd2;
            check($sformatf("sv_grant_%0d", i), g, 32'(exp_grants[i]));
        end
        for (int i = 0; i < 8; i++) tick();
        check("sv_busy_end", busy, 0);
        check("ack_exclusive", both_ack, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
